dist4_frame_gen: RTL and testbench
==================================

Name: dist4_frame_gen

Overview:
- Producer side of the four-lane distance interface consumed by the minimum-search tree.
- Streams one feature frame against four template streams and accumulates a saturating sum of absolute differences (SAD) per template.
- At end of frame, presents the four distances with a one-cycle enable pulse on every lane.
- Sits between the feature-extraction/template-fetch logic and the MIN4 comparator tree.

Parameters:
DATA_WIDTH, 16, width of each output distance (unsigned, saturating)
SAMPLE_WIDTH, 16, width of feature and template samples (two's complement)
FRAME_LEN, 32, samples per frame (>=1); counter width = clog2(FRAME_LEN)+1

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  synchronous reset, active-high
start  in  1  single-cycle frame start request
abort  in  1  cancel current frame
sample_valid  in  1  feat/tmpl samples valid this cycle
feat  in  SAMPLE_WIDTH  feature sample, signed
tmpl_1  in  SAMPLE_WIDTH  template 1 sample, signed
tmpl_2  in  SAMPLE_WIDTH  template 2 sample, signed
tmpl_3  in  SAMPLE_WIDTH  template 3 sample, signed
tmpl_4  in  SAMPLE_WIDTH  template 4 sample, signed
busy  out  1  high when state != IDLE
distance_DATA1  out  DATA_WIDTH  SAD, template 1
distance_DATA_2  out  DATA_WIDTH  SAD, template 2
distance_DATA_3  out  DATA_WIDTH  SAD, template 3
distance_DATA_4  out  DATA_WIDTH  SAD, template 4
distance_EN_1  out  1  distance strobe, lane 1
distance_EN_2  out  1  distance strobe, lane 2
distance_EN_3  out  1  distance strobe, lane 3
distance_EN_4  out  1  distance strobe, lane 4

Behaviour:
- Clock is clk; reset is rst: synchronous, active-high. On reset: state IDLE, busy=0, all distance_DATA*=0, all distance_EN_*=0, accumulators=0, sample counter=0.
- FSM states:
  - IDLE: start=1 -> ACC, clear accumulators and counter. sample_valid is ignored.
  - ACC: each cycle with sample_valid=1, acc_k <= sat(acc_k + |feat - tmpl_k|) for k=1..4 and cnt <= cnt+1. When the accepted sample has cnt==FRAME_LEN-1 -> OUT. sample_valid=0 holds all state.
  - OUT: single cycle. Distances register the final accumulator values; all four distance_EN_* are 1; next state IDLE.
- Arithmetic: difference computed at SAMPLE_WIDTH+1 bits signed, then abs (max 2^SAMPLE_WIDTH). Accumulators are DATA_WIDTH+1 bits internally; results clamp to 2^DATA_WIDTH-1 and stay clamped.
- The final sample's contribution is included in the output (next-value accumulation, not stale register).
- Latency: distance_EN_* rises the cycle after the clock edge that accepts the FRAME_LEN-th valid sample; pulse width is exactly 1 cycle. All four EN are identical every cycle.
- distance_DATA* update only on entry to OUT and hold until the next OUT or reset. Abort and a new start do not alter them.
- busy = 1 in ACC and OUT.
- start while busy (ACC or OUT) is ignored. start and abort together in IDLE: abort wins, stay IDLE.
- abort in ACC: -> IDLE next cycle, no EN, accumulators cleared. A valid sample in the same cycle is discarded. abort in OUT: ignored, EN still fires.
- FRAME_LEN=1: first valid sample goes straight to OUT.
- rst asserted mid-frame or during OUT: reset values take effect next edge. EN is not emitted.

Test Plan:
- Reset: hold rst 3 cycles with start=1, sample_valid=1 -> busy=0, all DATA=0, all EN=0 throughout.
- FRAME_LEN=4; feat=100, tmpl=100/90/-100/110 for 4 back-to-back valids -> one-cycle EN on all lanes exactly 1 cycle after the 4th valid; DATA1=0, DATA_2=40, DATA_3=800, DATA_4=40; values held afterwards.
- Same frame with sample_valid toggling 1,0,1,0… -> identical results; EN only after the 4th valid; busy high from the cycle after start until after OUT.
- Saturation: FRAME_LEN=4, feat=32767, tmpl_1=-32768 (per-sample diff 65535) -> DATA1=65535; tmpl_2=32767 -> DATA_2=0.
- Handshake: start pulse mid-frame ignored (result unchanged); abort after 2 samples -> IDLE, no EN, previous DATA retained; new start then completes normally.
- rst asserted after 3 of 4 samples -> no EN, outputs 0; subsequent full frame produces correct SAD from zero.

Source files
------------

// File: rtl/dist4_frame_gen.sv
// Four-lane SAD frame generator feeding the MIN4 comparator tree.
// Ports: clk, rst (sync, active-high); start/abort frame control;
//   sample_valid with signed feat and tmpl_1..tmpl_4 samples;
//   busy; distance_DATA* saturating SADs with distance_EN_* strobes.
module dist4_frame_gen #(
    parameter int DATA_WIDTH   = 16,
    parameter int SAMPLE_WIDTH = 16,
    parameter int FRAME_LEN    = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           abort,
    input  logic                           sample_valid,
    input  logic signed [SAMPLE_WIDTH-1:0] feat,
    input  logic signed [SAMPLE_WIDTH-1:0] tmpl_1,
    input  logic signed [SAMPLE_WIDTH-1:0] tmpl_2,
    input  logic signed [SAMPLE_WIDTH-1:0] tmpl_3,
    input  logic signed [SAMPLE_WIDTH-1:0] tmpl_4,
    output logic                           busy,
    output logic [DATA_WIDTH-1:0]          distance_DATA1,
    output logic [DATA_WIDTH-1:0]          distance_DATA_2,
    output logic [DATA_WIDTH-1:0]          distance_DATA_3,
    output logic [DATA_WIDTH-1:0]          distance_DATA_4,
    output logic                           distance_EN_1,
    output logic                           distance_EN_2,
    output logic                           distance_EN_3,
    output logic                           distance_EN_4
);

    localparam int CW  = $clog2(FRAME_LEN) + 1;
    localparam int AW  = DATA_WIDTH + 1;
    localparam int DFW = SAMPLE_WIDTH + 1;
    // Sum width covers accumulator plus largest magnitude without wrap.
    localparam int SW  = ((AW > DFW) ? AW : DFW) + 1;

    localparam logic [SW-1:0] SAT  = SW'({DATA_WIDTH{1'b1}});
    localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        OUT
    } state_e;

    state_e                 state_q;
    logic [CW-1:0]          cnt_q;
    logic [AW-1:0]          acc_q  [4];
    logic [AW-1:0]          acc_d  [4];
    logic [DATA_WIDTH-1:0]  dist_q [4];
    logic                   en_q;
    logic                   busy_q;

    logic signed [SAMPLE_WIDTH-1:0] tmpl [4];
    logic signed [DFW-1:0]          diff [4];
    logic        [DFW-1:0]          mag  [4];
    logic        [SW-1:0]           sum  [4];

    assign tmpl[0] = tmpl_1;
    assign tmpl[1] = tmpl_2;
    assign tmpl[2] = tmpl_3;
    assign tmpl[3] = tmpl_4;

    // Next-value accumulation so the last sample lands in the output.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            diff[k]  = DFW'(feat) - DFW'(tmpl[k]);
            mag[k]   = diff[k][DFW-1] ? DFW'(-diff[k]) : DFW'(diff[k]);
            sum[k]   = SW'(acc_q[k]) + SW'(mag[k]);
            acc_d[k] = (sum[k] > SAT) ? AW'(SAT) : AW'(sum[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                acc_q[k]  <= '0;
                dist_q[k] <= '0;
            end
        end else begin
            en_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        state_q <= ACC;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        for (int k = 0; k < 4; k++) acc_q[k] <= '0;
                    end
                end
                ACC: begin
                    if (abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                        for (int k = 0; k < 4; k++) acc_q[k] <= '0;
                    end else if (sample_valid) begin
                        cnt_q <= cnt_q + CW'(1);
                        for (int k = 0; k < 4; k++) acc_q[k] <= acc_d[k];
                        if (cnt_q == LAST) begin
                            state_q <= OUT;
                            en_q    <= 1'b1;
                            for (int k = 0; k < 4; k++)
                                dist_q[k] <= acc_d[k][DATA_WIDTH-1:0];
                        end
                    end
                end
                OUT: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy            = busy_q;
    assign distance_DATA1  = dist_q[0];
    assign distance_DATA_2 = dist_q[1];
    assign distance_DATA_3 = dist_q[2];
    assign distance_DATA_4 = dist_q[3];
    assign distance_EN_1   = en_q;
    assign distance_EN_2   = en_q;
    assign distance_EN_3   = en_q;
    assign distance_EN_4   = en_q;

endmodule

// File: tb/tb_dist4_frame_gen.sv
// Randomized bench for dist4_frame_gen (FRAME_LEN=4) against
// a frame-level integer SAD model.
module tb_dist4_frame_gen;

    localparam int FL  = 4;
    localparam int MAXD = 65535;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic               sample_valid = 1'b0;
    logic signed [15:0] feat = '0;
    logic signed [15:0] tmpl_1 = '0;
    logic signed [15:0] tmpl_2 = '0;
    logic signed [15:0] tmpl_3 = '0;
    logic signed [15:0] tmpl_4 = '0;
    logic               busy;
    logic [15:0]        d1, d2, d3, d4;
    logic               e1, e2, e3, e4;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    bit m_active = 0;
    bit m_out    = 0;
    int m_cnt    = 0;
    int m_sum  [4];
    int m_data [4];

    dist4_frame_gen #(
        .DATA_WIDTH  (16),
        .SAMPLE_WIDTH(16),
        .FRAME_LEN   (FL)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .abort          (abort),
        .sample_valid   (sample_valid),
        .feat           (feat),
        .tmpl_1         (tmpl_1),
        .tmpl_2         (tmpl_2),
        .tmpl_3         (tmpl_3),
        .tmpl_4         (tmpl_4),
        .busy           (busy),
        .distance_DATA1 (d1),
        .distance_DATA_2(d2),
        .distance_DATA_3(d3),
        .distance_DATA_4(d4),
        .distance_EN_1  (e1),
        .distance_EN_2  (e2),
        .distance_EN_3  (e3),
        .distance_EN_4  (e4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Frame-level behaviour applied once per clock edge.
    task automatic model_step();
        int t [4];
        int d;
        t[0] = int'(tmpl_1);
        t[1] = int'(tmpl_2);
        t[2] = int'(tmpl_3);
        t[3] = int'(tmpl_4);
        if (rst) begin
            m_active = 0;
            m_out    = 0;
            m_cnt    = 0;
            for (int k = 0; k < 4; k++) begin
                m_sum[k]  = 0;
                m_data[k] = 0;
            end
        end else if (m_out) begin
            m_out = 0;
        end else if (!m_active) begin
            if (start && !abort) begin
                m_active = 1;
                m_cnt    = 0;
                for (int k = 0; k < 4; k++) m_sum[k] = 0;
            end
        end else if (abort) begin
            m_active = 0;
        end else if (sample_valid) begin
            for (int k = 0; k < 4; k++) begin
                d = int'(feat) - t[k];
                if (d < 0) d = -d;
                m_sum[k] = m_sum[k] + d;
                if (m_sum[k] > MAXD) m_sum[k] = MAXD;
            end
            m_cnt++;
            if (m_cnt == FL) begin
                m_active = 0;
                m_out    = 1;
                for (int k = 0; k < 4; k++) m_data[k] = m_sum[k];
            end
        end
    endtask

    task automatic compare_all();
        int en;
        en = m_out ? 1 : 0;
        check("busy", int'(busy), (m_active || m_out) ? 1 : 0);
        check("en1", int'(e1), en);
        check("en2", int'(e2), en);
        check("en3", int'(e3), en);
        check("en4", int'(e4), en);
        check("data1", int'(d1), m_data[0]);
        check("data2", int'(d2), m_data[1]);
        check("data3", int'(d3), m_data[2]);
        check("data4", int'(d4), m_data[3]);
    endtask

    task automatic step(input logic r, input logic s, input logic a,
                        input logic v, input logic signed [15:0] f,
                        input logic signed [15:0] t1,
                        input logic signed [15:0] t2,
                        input logic signed [15:0] t3,
                        input logic signed [15:0] t4);
        rst          = r;
        start        = s;
        abort        = a;
        sample_valid = v;
        feat         = f;
        tmpl_1       = t1;
        tmpl_2       = t2;
        tmpl_3       = t3;
        tmpl_4       = t4;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic basic(input logic v);
        step(0, 0, 0, v, 100, 100, 90, -100, 110);
    endtask

    function automatic logic signed [15:0] rs();
        case ($urandom_range(0, 7))
            0:       return 16'sh7fff;
            1:       return 16'sh8000;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        for (int k = 0; k < 4; k++) begin
            m_sum[k]  = 0;
            m_data[k] = 0;
        end

        // Reset held with start and valid asserted
        for (int i = 0; i < 3; i++)
            step(1, 1, 0, 1, 5, 1, 2, 3, 4);
        idle(1);

        // Back-to-back frame
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) basic(1);
        check("en_after4", int'(e1), 1);
        check("sad1", int'(d1), 0);
        check("sad2", int'(d2), 40);
        check("sad3", int'(d3), 800);
        check("sad4", int'(d4), 40);
        idle(3);
        check("hold3", int'(d3), 800);

        // Same frame with gapped valids
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        check("busy_gap", int'(busy), 1);
        for (int i = 0; i < 4; i++) begin
            basic(1);
            if (i < 3) basic(0);
        end
        check("sad3_gap", int'(d3), 800);
        idle(2);

        // Saturation
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            step(0, 0, 0, 1, 16'sh7fff, 16'sh8000, 16'sh7fff, 0, -1);
        check("sat1", int'(d1), MAXD);
        check("sat2", int'(d2), 0);
        idle(2);

        // Start mid-frame ignored, abort after 2, then a fresh frame
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        basic(1);
        step(0, 1, 0, 1, 100, 100, 90, -100, 110);
        basic(1);
        basic(1);
        check("sad2_mid", int'(d2), 40);
        idle(1);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 7, 1, 2, 3, 4);
        step(0, 0, 0, 1, 7, 1, 2, 3, 4);
        step(0, 0, 1, 1, 7, 1, 2, 3, 4);
        check("sad4_abort", int'(d4), 40);
        step(0, 1, 1, 0, 0, 0, 0, 0, 0);
        idle(1);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 10, 0, 20, -10, 10);
        check("sad1_new", int'(d1), 40);
        check("sad3_new", int'(d3), 80);
        idle(1);

        // Reset mid-frame, then a full frame from zero
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) basic(1);
        step(1, 0, 0, 1, 100, 100, 90, -100, 110);
        check("rst_data3", int'(d3), 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) basic(1);
        check("sad3_post", int'(d3), 800);
        idle(1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 2) != 0),
                 rs(), rs(), rs(), rs(), rs());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
